// File: rtl/mem_align_unit.sv
// Load/store alignment between the EX/MEM register and a word-addressed data memory.
// Latency: 0 cycles for aligned accesses, 1 extra cycle for a word-crossing (split) access.
// Backpressure: stall is raised during the first half of a split access; the pipeline must hold its inputs.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid                MEM-stage instruction carries a memory access
//   MemWrite, MemRead        store / load (both set is treated as a store)
//   DMType                   000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//   addr, din                byte address, store data
//   mem_rdata                word read from memory at mem_addr (combinational)
//   mem_addr/we/be/wdata     word address, write enable, byte enables, lane-aligned write data
//   rdata                    extended load result, valid when stall is low
//   stall, misalign          pipeline freeze, current access crosses a word boundary
//   mis_cnt                  saturating count of split accesses
module mem_align_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [2:0]       DMType,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic [31:0]      mem_rdata,
  output logic [29:0]      mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             misalign,
  output logic [CNT_W-1:0] mis_cnt
);

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t           r_state;
  logic [31:0]      r_hold;
  logic [CNT_W-1:0] r_mis_cnt;

  logic [1:0]  w_k;
  logic [4:0]  w_sh;
  logic        w_is_word, w_is_half, w_is_byte, w_signed, w_type_ok;
  logic [3:0]  w_size_mask;
  logic        w_act, w_store, w_cross, w_second;
  logic [7:0]  w_be_wide;
  logic [63:0] w_wdata_wide;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  assign w_k       = addr[1:0];
  assign w_sh      = {w_k, 3'b000};
  assign w_is_word = (DMType == 3'b000);
  assign w_is_half = (DMType == 3'b001) || (DMType == 3'b010);
  assign w_is_byte = (DMType == 3'b011) || (DMType == 3'b100);
  assign w_signed  = (DMType == 3'b001) || (DMType == 3'b011);
  assign w_type_ok = w_is_word | w_is_half | w_is_byte;
  assign w_size_mask = w_is_word ? 4'b1111 : (w_is_half ? 4'b0011 : (w_is_byte ? 4'b0001 : 4'b0000));

  // rst is folded in so that stall/we/be drop immediately while reset is held.
  assign w_act    = req_valid & w_type_ok & (MemWrite | MemRead) & ~rst;
  assign w_store  = MemWrite;
  assign w_cross  = w_act & ((w_is_word & (w_k != 2'd0)) | (w_is_half & (w_k == 2'd3)));
  assign w_second = (r_state == S_SECOND);

  // Lower nibble / word is the first part, upper nibble / word spills into the next word.
  assign w_be_wide    = {4'b0000, w_size_mask} << w_k;
  assign w_wdata_wide = {32'h0, din} << w_sh;

  // In the second part the low bytes come from the word captured in the first cycle.
  // k is never 0 there, so the left shift amount stays below 32.
  always_comb begin
    w_lane = mem_rdata >> w_sh;
    if (w_second)
      w_lane = (r_hold >> w_sh) | (mem_rdata << (6'd32 - {1'b0, w_sh}));
  end

  always_comb begin
    w_ext = 32'h0;
    if (w_is_word)
      w_ext = w_lane;
    else if (w_is_half)
      w_ext = {{16{w_signed & w_lane[15]}}, w_lane[15:0]};
    else if (w_is_byte)
      w_ext = {{24{w_signed & w_lane[7]}}, w_lane[7:0]};
  end

  always_comb begin
    mem_addr  = w_second ? (addr[31:2] + 30'd1) : addr[31:2];
    mem_we    = w_act & w_store;
    mem_be    = 4'b0000;
    if (w_act & w_store)
      mem_be = w_second ? w_be_wide[7:4] : w_be_wide[3:0];
    mem_wdata = w_second ? w_wdata_wide[63:32] : w_wdata_wide[31:0];
    stall     = w_cross & ~w_second;
    misalign  = w_second | w_cross;
    rdata     = 32'h0;
    if (w_act & ~w_store & ~stall)
      rdata = w_ext;
    mis_cnt   = r_mis_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hold    <= 32'h0;
      r_mis_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cross) begin
            r_state <= S_SECOND;
            r_hold  <= mem_rdata;
            if (r_mis_cnt != {CNT_W{1'b1}})
              r_mis_cnt <= r_mis_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_SECOND: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, MemWrite, MemRead;
  logic [2:0]  DMType;
  logic [31:0] addr, din, mem_rdata;
  logic [29:0] mem_addr, mem_addr2;
  logic        mem_we, mem_we2;
  logic [3:0]  mem_be, mem_be2;
  logic [31:0] mem_wdata, mem_wdata2, rdata, rdata2;
  logic        stall, stall2, misalign, misalign2;
  logic [15:0] mis_cnt;
  logic [1:0]  mis_cnt2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];

  typedef struct {
    string       tag;
    logic        st;
    logic [29:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        cw;
    logic [31:0] rd;
    logic        cr;
    logic        mis;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_align_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMType(DMType), .addr(addr), .din(din), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .mis_cnt(mis_cnt)
  );

  // Narrow-counter instance shares the stimulus; only its counter is checked.
  mem_align_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMType(DMType), .addr(addr), .din(din), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_be(mem_be2), .mem_wdata(mem_wdata2),
    .rdata(rdata2), .stall(stall2), .misalign(misalign2), .mis_cnt(mis_cnt2)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid && !rst) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cycle: got output with addr=%h expected none", addr);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.tag, ".stall"}, {31'h0, stall}, {31'h0, mon_e.st});
        chk({mon_e.tag, ".mem_addr"}, {2'b00, mem_addr}, {2'b00, mon_e.a});
        chk({mon_e.tag, ".mem_we"}, {31'h0, mem_we}, {31'h0, mon_e.we});
        chk({mon_e.tag, ".mem_be"}, {28'h0, mem_be}, {28'h0, mon_e.be});
        chk({mon_e.tag, ".misalign"}, {31'h0, misalign}, {31'h0, mon_e.mis});
        if (mon_e.cw) chk({mon_e.tag, ".wdata"}, mem_wdata, mon_e.wd);
        if (mon_e.cr) chk({mon_e.tag, ".rdata"}, rdata, mon_e.rd);
      end
    end
  end

  task automatic push(input string tag, input logic st, input logic [29:0] a, input logic we,
                      input logic [3:0] be, input logic [31:0] wd, input logic cw,
                      input logic [31:0] rd, input logic cr, input logic mis);
    exp_t e;
    e.tag = tag; e.st = st; e.a = a; e.we = we; e.be = be;
    e.wd = wd; e.cw = cw; e.rd = rd; e.cr = cr; e.mis = mis;
    q.push_back(e);
  endtask

  // Presents one access for n cycles, then removes it (called at posedge+1).
  task automatic acc(input logic w, input logic r, input logic [2:0] dm,
                     input logic [31:0] a, input logic [31:0] d, input int n);
    MemWrite = w; MemRead = r; DMType = dm; addr = a; din = d; req_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    req_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    DMType = 3'b000; addr = 32'h0; din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a split store presented while reset is held.
    req_valid = 1'b1; MemWrite = 1'b1; addr = 32'h102; din = 32'h11223344;
    #1;
    chk("rst.stall", {31'h0, stall}, 32'h0);
    chk("rst.mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst.mis_cnt", {16'h0, mis_cnt}, 32'h0);
    req_valid = 1'b0; MemWrite = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: aligned word store
    push("sw100", 0, 30'h40, 1, 4'b1111, 32'hDEADBEEF, 1, 32'h0, 0, 0);
    acc(1, 0, 3'b000, 32'h100, 32'hDEADBEEF, 1);
    // 2: byte store to lane 3, byte loads back; aligned half loads
    push("sb103", 0, 30'h40, 1, 4'b1000, 32'hA5000000, 1, 32'h0, 0, 0);
    acc(1, 0, 3'b011, 32'h103, 32'h000000A5, 1);
    push("lbu103", 0, 30'h40, 0, 4'b0000, 32'h0, 0, 32'h000000A5, 1, 0);
    acc(0, 1, 3'b100, 32'h103, 32'h0, 1);
    push("lb103", 0, 30'h40, 0, 4'b0000, 32'h0, 0, 32'hFFFFFFA5, 1, 0);
    acc(0, 1, 3'b011, 32'h103, 32'h0, 1);
    push("lh100", 0, 30'h40, 0, 4'b0000, 32'h0, 0, 32'hFFFFBEEF, 1, 0);
    acc(0, 1, 3'b001, 32'h100, 32'h0, 1);
    push("lhu102", 0, 30'h40, 0, 4'b0000, 32'h0, 0, 32'h0000A5AD, 1, 0);
    acc(0, 1, 3'b010, 32'h102, 32'h0, 1);

    // 3: split word store, then split word load of the same bytes
    push("sw102.p1", 1, 30'h40, 1, 4'b1100, 32'h33440000, 1, 32'h0, 0, 1);
    push("sw102.p2", 0, 30'h41, 1, 4'b0011, 32'h00001122, 1, 32'h0, 0, 1);
    acc(1, 0, 3'b000, 32'h102, 32'h11223344, 2);
    chk("sw102.mis_cnt", {16'h0, mis_cnt}, 32'd1);
    push("lw102.p1", 1, 30'h40, 0, 4'b0000, 32'h0, 0, 32'h0, 0, 1);
    push("lw102.p2", 0, 30'h41, 0, 4'b0000, 32'h0, 0, 32'h11223344, 1, 1);
    acc(0, 1, 3'b000, 32'h102, 32'h0, 2);

    // 4: half load across words 0x41/0x42
    push("sb107", 0, 30'h41, 1, 4'b1000, 32'h80000000, 1, 32'h0, 0, 0);
    acc(1, 0, 3'b011, 32'h107, 32'h00000080, 1);
    push("sb108", 0, 30'h42, 1, 4'b0001, 32'h0000007F, 1, 32'h0, 0, 0);
    acc(1, 0, 3'b011, 32'h108, 32'h0000007F, 1);
    push("lh106", 0, 30'h41, 0, 4'b0000, 32'h0, 0, 32'hFFFF8000, 1, 0);
    acc(0, 1, 3'b001, 32'h106, 32'h0, 1);
    push("lhu106", 0, 30'h41, 0, 4'b0000, 32'h0, 0, 32'h00008000, 1, 0);
    acc(0, 1, 3'b010, 32'h106, 32'h0, 1);
    push("lh107.p1", 1, 30'h41, 0, 4'b0000, 32'h0, 0, 32'h0, 0, 1);
    push("lh107.p2", 0, 30'h42, 0, 4'b0000, 32'h0, 0, 32'h00007F80, 1, 1);
    acc(0, 1, 3'b001, 32'h107, 32'h0, 2);
    push("lhu107.p1", 1, 30'h41, 0, 4'b0000, 32'h0, 0, 32'h0, 0, 1);
    push("lhu107.p2", 0, 30'h42, 0, 4'b0000, 32'h0, 0, 32'h00007F80, 1, 1);
    acc(0, 1, 3'b010, 32'h107, 32'h0, 2);
    chk("t4.mis_cnt", {16'h0, mis_cnt}, 32'd4);
    chk("t4.mis_cnt_w2", {30'h0, mis_cnt2}, 32'd3);

    // 5: reset during the second part of a split store
    push("sw109.p1", 1, 30'h42, 1, 4'b1110, 32'hBBCCDD00, 1, 32'h0, 0, 1);
    MemWrite = 1'b1; MemRead = 1'b0; DMType = 3'b000; addr = 32'h109; din = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5.rst_stall", {31'h0, stall}, 32'h0);
    chk("t5.rst_we", {31'h0, mem_we}, 32'h0);
    chk("t5.rst_be", {28'h0, mem_be}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; MemWrite = 1'b0; rst = 1'b0;
    #1;
    chk("t5.mis_cnt", {16'h0, mis_cnt}, 32'h0);
    chk("t5.mis_cnt_w2", {30'h0, mis_cnt2}, 32'h0);
    chk("t5.stall", {31'h0, stall}, 32'h0);
    chk("t5.word42", mem[8'h42], 32'hBBCCDD7F);
    chk("t5.word43", mem[8'h43], 32'h00000000);
    @(posedge clk); #1;

    // 6: five split loads saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      push($sformatf("lw101_%0d.p1", i), 1, 30'h40, 0, 4'b0000, 32'h0, 0, 32'h0, 0, 1);
      push($sformatf("lw101_%0d.p2", i), 0, 30'h41, 0, 4'b0000, 32'h0, 0, 32'h223344BE, 1, 1);
      acc(0, 1, 3'b000, 32'h101, 32'h0, 2);
    end
    chk("t6.mis_cnt_w2", {30'h0, mis_cnt2}, 32'd3);
    chk("t6.mis_cnt", {16'h0, mis_cnt}, 32'd5);

    // Split store whose second word address wraps to 0
    push("swwrap.p1", 1, 30'h3FFFFFFF, 1, 4'b1100, 32'hF00D0000, 1, 32'h0, 0, 1);
    push("swwrap.p2", 0, 30'h00000000, 1, 4'b0011, 32'h0000CAFE, 1, 32'h0, 0, 1);
    acc(1, 0, 3'b000, 32'hFFFFFFFE, 32'hCAFEF00D, 2);
    chk("wrap.word00", mem[8'h00], 32'h0000CAFE);
    chk("wrap.mis_cnt", {16'h0, mis_cnt}, 32'd6);

    // Reserved DMType store: nothing happens
    push("dm111", 0, 30'h40, 0, 4'b0000, 32'h0, 0, 32'h0, 1, 0);
    acc(1, 0, 3'b111, 32'h102, 32'h12345678, 1);
    chk("dm111.word40", mem[8'h40], 32'h3344BEEF);
    chk("dm111.mis_cnt", {16'h0, mis_cnt}, 32'd6);

    // No req_valid: store request is ignored
    MemWrite = 1'b1; DMType = 3'b000; addr = 32'h102; din = 32'h55555555;
    #1;
    chk("novld.stall", {31'h0, stall}, 32'h0);
    chk("novld.we", {31'h0, mem_we}, 32'h0);
    chk("novld.be", {28'h0, mem_be}, 32'h0);
    chk("novld.rdata", rdata, 32'h0);
    MemWrite = 1'b0;
    @(posedge clk); #1;

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
